mmio_host_master: RTL
=====================

MMIO_HOST_MASTER -- requirements
Module: mmio_host_master

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 512: cycles to wait for a read response before reporting an error.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous and active-high.
REQ-004 cmd_valid  in  1 / cmd_ready  out  1  command handshake; a command transfers when both are high on a clock edge.
REQ-005 cmd_write  in  1 (1=write, 0=read) / cmd_addr  in  16 (4-byte word address) / cmd_wdata  in  64  command payload.
REQ-006 rsp_valid  out  1 / rsp_ready  in  1  read-response handshake.
REQ-007 rsp_rdata  out  64 (read data) / rsp_err  out  1 (timeout or misaligned address).
REQ-008 mmio_wr_valid  out  1 / mmio_rd_valid  out  1  single-cycle MMIO request strobes toward the AFU.
REQ-009 mmio_addr  out  16 / mmio_tid  out  9 / mmio_length  out  2 (constant 2'b01 = 8 bytes) / mmio_wdata  out  64  request header and data.
REQ-010 rd_rsp_valid  in  1 / rd_rsp_tid  in  9 / rd_rsp_data  in  64  AFU read-response channel.
REQ-011 stale_rsp_cnt  out  8  saturating count of responses that were not matched.

Function
REQ-012 FSM states: IDLE, RD_WAIT, RSP; cmd_ready SHALL be high only in IDLE.
REQ-013 Write accepted in IDLE -> next cycle mmio_wr_valid=1 for exactly one cycle, with mmio_addr and mmio_wdata from the command; FSM stays IDLE; writes produce no response.
REQ-014 Read accepted in IDLE with cmd_addr[0]=0 -> next cycle mmio_rd_valid=1 for exactly one cycle, mmio_tid=current tid; tid then increments mod 512; FSM -> RD_WAIT.
REQ-015 Accepted command with cmd_addr[0]=1 -> no MMIO strobe; FSM -> RSP with rsp_err=1 and rsp_rdata=0; this applies to both reads and writes.
REQ-016 RD_WAIT: rd_rsp_valid with rd_rsp_tid equal to the outstanding tid -> capture rd_rsp_data into rsp_rdata, rsp_err=0, FSM -> RSP.
REQ-017 RD_WAIT: a 16-bit wait counter counts up from 0; when it reaches TIMEOUT_CYCLES-1 with no match -> rsp_rdata=0, rsp_err=1, FSM -> RSP.
REQ-018 If a match and the timeout occur in the same cycle, the match SHALL win.
REQ-019 Any rd_rsp_valid in IDLE or RSP, or with a non-matching tid in RD_WAIT -> stale_rsp_cnt increments, saturating at 255; FSM state is unchanged.
REQ-020 RSP: rsp_valid=1, and rsp_rdata/rsp_err are held stable until rsp_ready; on the handshake -> IDLE; cmd_ready returns high the following cycle.
REQ-021 At most one read is outstanding; mmio_rd_valid and mmio_wr_valid are never high in the same cycle.
REQ-022 Latency: read command accept to mmio_rd_valid = 1 cycle; matching response to rsp_valid = 1 cycle.

Reset
REQ-023 While rst is high: FSM=IDLE; tid=0; wait counter=0; stale_rsp_cnt=0; every valid/strobe output=0; mmio_addr, mmio_wdata, mmio_tid and rsp_rdata=0; rsp_err=0; mmio_length=2'b01.
REQ-024 Reset asserted mid-read abandons the outstanding tid; a later response carrying that tid SHALL be counted as stale.

Structure
REQ-025 The state enum, MMIO_LEN_8B=2'b01 and the tid width (9) SHALL live in a shared package, mmio_pkg.
REQ-026 One sub-module, mmio_timeout_ctr (clear, enable, expire output), SHALL hold the wait counter; everything else stays in mmio_host_master.

Verification
REQ-027 Write: addr 0x0020, data 0xDEADBEEF -> one cycle later mmio_wr_valid=1 for 1 cycle with addr 0x0020 and data 0xDEADBEEF; rsp_valid stays 0.
REQ-028 Read: addr 0x0020 with tid 0; AFU returns tid 0 with data 0x1234 three cycles later -> rsp_valid=1, rsp_rdata=0x1234, rsp_err=0; the next read uses tid 1.
REQ-029 Timeout: read with no AFU response -> rsp_valid=1 with rsp_err=1 exactly TIMEOUT_CYCLES cycles after mmio_rd_valid; a late response then increments stale_rsp_cnt to 1.
REQ-030 Misaligned: read of addr 0x0003 -> no mmio_rd_valid, rsp_err=1, rsp_rdata=0.
REQ-031 Backpressure: hold rsp_ready=0 for 10 cycles -> rsp holds stable and cmd_ready=0 throughout; after rsp_ready=1, cmd_ready=1 the next cycle.
REQ-032 Tid wrap: issue 513 reads -> tid sequence runs 0..511 then 0; wrong-tid responses are counted and never matched.

Source files
------------

// File: rtl/mmio_pkg.sv
// Shared types and constants for the MMIO host master and its timeout counter.
package mmio_pkg;

  localparam int unsigned TID_W       = 9;
  localparam logic [1:0]  MMIO_LEN_8B = 2'b01;

  typedef logic [TID_W-1:0] tid_t;

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    RSP
  } state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/mmio_host_master_if.sv
// Host command/response, AFU MMIO request and AFU read-response signals.
interface mmio_host_master_if;

  logic                cmd_valid;
  logic                cmd_ready;
  logic                cmd_write;
  logic [15:0]         cmd_addr;
  logic [63:0]         cmd_wdata;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [63:0]         rsp_rdata;
  logic                rsp_err;
  logic                mmio_wr_valid;
  logic                mmio_rd_valid;
  logic [15:0]         mmio_addr;
  mmio_pkg::tid_t      mmio_tid;
  logic [1:0]          mmio_length;
  logic [63:0]         mmio_wdata;
  logic                rd_rsp_valid;
  mmio_pkg::tid_t      rd_rsp_tid;
  logic [63:0]         rd_rsp_data;
  logic [7:0]          stale_rsp_cnt;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
           rd_rsp_valid, rd_rsp_tid, rd_rsp_data,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
           mmio_wr_valid, mmio_rd_valid, mmio_addr, mmio_tid, mmio_length,
           mmio_wdata, stale_rsp_cnt
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
           rd_rsp_valid, rd_rsp_tid, rd_rsp_data,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
           mmio_wr_valid, mmio_rd_valid, mmio_addr, mmio_tid, mmio_length,
           mmio_wdata, stale_rsp_cnt
  );

endinterface

// File: rtl/mmio_timeout_ctr.sv
// Read-response wait counter; expire asserts once the count reaches LIMIT-1.
module mmio_timeout_ctr #(
  parameter int unsigned LIMIT = 512
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [15:0] LAST = 16'(LIMIT - 1);

  logic [15:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable && !expire) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign expire = (cnt_q == LAST);

endmodule

// File: rtl/mmio_host_master.sv
// Turns host read/write commands into single-cycle MMIO requests and
// matches AFU read responses by transaction id, with a response timeout.
module mmio_host_master
  import mmio_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 512
) (
  input  logic                clk,
  input  logic                rst,
  mmio_host_master_if.master  bus
);

  state_e      state_q;
  tid_t        tid_q;
  tid_t        mmio_tid_q;
  logic        wr_valid_q;
  logic        rd_valid_q;
  logic [15:0] addr_q;
  logic [63:0] wdata_q;
  logic [63:0] rdata_q;
  logic        err_q;
  logic [7:0]  stale_q;
  logic        expire;
  logic        match;

  mmio_timeout_ctr #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (state_q != RD_WAIT),
    .enable (state_q == RD_WAIT),
    .expire (expire)
  );

  assign match = bus.rd_rsp_valid && (state_q == RD_WAIT) &&
                 (bus.rd_rsp_tid == mmio_tid_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      tid_q      <= '0;
      mmio_tid_q <= '0;
      wr_valid_q <= 1'b0;
      rd_valid_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      stale_q    <= '0;
    end else begin
      wr_valid_q <= 1'b0;
      rd_valid_q <= 1'b0;
      if (bus.rd_rsp_valid && !match) begin
        stale_q <= sat_inc8(stale_q);
      end
      case (state_q)
        IDLE: begin
          // cmd_ready is high throughout IDLE, so cmd_valid alone is a transfer
          if (bus.cmd_valid) begin
            if (bus.cmd_addr[0]) begin
              rdata_q <= '0;
              err_q   <= 1'b1;
              state_q <= RSP;
            end else if (bus.cmd_write) begin
              wr_valid_q <= 1'b1;
              addr_q     <= bus.cmd_addr;
              wdata_q    <= bus.cmd_wdata;
            end else begin
              rd_valid_q <= 1'b1;
              addr_q     <= bus.cmd_addr;
              mmio_tid_q <= tid_q;
              tid_q      <= tid_q + tid_t'(1);
              state_q    <= RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          if (match) begin
            rdata_q <= bus.rd_rsp_data;
            err_q   <= 1'b0;
            state_q <= RSP;
          end else if (expire) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
            state_q <= RSP;
          end
        end
        RSP: begin
          if (bus.rsp_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready     = (state_q == IDLE);
  assign bus.rsp_valid     = (state_q == RSP);
  assign bus.rsp_rdata     = rdata_q;
  assign bus.rsp_err       = err_q;
  assign bus.mmio_wr_valid = wr_valid_q;
  assign bus.mmio_rd_valid = rd_valid_q;
  assign bus.mmio_addr     = addr_q;
  assign bus.mmio_tid      = mmio_tid_q;
  assign bus.mmio_length   = MMIO_LEN_8B;
  assign bus.mmio_wdata    = wdata_q;
  assign bus.stale_rsp_cnt = stale_q;

endmodule
